// File: rtl/issue_unit_pkg.sv
// Shared widths, opcode encodings and functional-unit class definitions for the issue unit.
package issue_unit_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int OPCODE_WIDTH = 6;
    localparam int FU_NUM       = 4;
    localparam int FU_INDEX     = 3;
    localparam int RB_INDEX     = 3;
    localparam int ALU_FU_BASE  = 0;
    localparam int ALU_FU_CNT   = 2;
    localparam int MEM_FU_BASE  = 2;
    localparam int MEM_FU_CNT   = 2;
    localparam int QUEUE_DEPTH  = 2;

    localparam logic [FU_INDEX-1:0] FU_NONE = FU_INDEX'(2**FU_INDEX - 1);

    localparam logic [OPCODE_WIDTH-1:0] INST_ADD   = 6'h01;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUB   = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] INST_MUL   = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] INST_ADDI  = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUBI  = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] INST_MULI  = 6'h06;
    localparam logic [OPCODE_WIDTH-1:0] INST_LOAD  = 6'h07;
    localparam logic [OPCODE_WIDTH-1:0] INST_STORE = 6'h08;

    typedef enum logic [1:0] {
        FU_CLASS_ALU  = 2'd0,
        FU_CLASS_MEM  = 2'd1,
        FU_CLASS_NONE = 2'd2
    } fu_class_t;

    function automatic fu_class_t decode_class(input logic [OPCODE_WIDTH-1:0] opcode);
        case (opcode)
            INST_ADD, INST_SUB, INST_MUL,
            INST_ADDI, INST_SUBI, INST_MULI: decode_class = FU_CLASS_ALU;
            INST_LOAD, INST_STORE:           decode_class = FU_CLASS_MEM;
            default:                         decode_class = FU_CLASS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/issue_unit_fifo.sv
// Small synchronous instruction FIFO; head is visible combinationally, flush empties it.
module issue_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/issue_unit.sv
// Dispatcher driving the <fu, RB_index, inst> broadcast; ISSUE_STATS_EN adds issue/stall counters.
module issue_unit
    import issue_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] inst_in,
    input  logic                 inst_valid,
    output logic                 inst_ready,
    input  logic [FU_NUM-1:0]    busy_in,
    input  logic                 rb_full,
    input  logic [RB_INDEX-1:0]  rb_tail,
    output logic                 rb_alloc,
    input  logic                 flush,
    output logic [FU_INDEX-1:0]  fu,
    output logic [RB_INDEX-1:0]  RB_index,
    output logic [WORD_SIZE-1:0] inst,
    output logic                 illegal
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);

    logic [WORD_SIZE-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 head_valid;
    fu_class_t            head_class;
    logic                 legal;
    logic [FU_NUM-1:0]    alu_range;
    logic [FU_NUM-1:0]    mem_range;
    logic [FU_NUM-1:0]    class_range;
    logic [FU_NUM-1:0]    free_mask;
    logic [FU_NUM-1:0]    claim_reg;
    logic [FU_NUM-1:0]    claim_next;
    logic [FU_INDEX-1:0]  cand;
    logic                 cand_found;
    logic                 issue;
    logic                 drop;
    logic                 pop;

    logic [FU_INDEX-1:0]  fu_reg;
    logic [RB_INDEX-1:0]  rb_index_reg;
    logic [WORD_SIZE-1:0] inst_reg;
    logic                 rb_alloc_reg;
    logic                 illegal_reg;

    issue_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (inst_valid),
        .pop     (pop),
        .din     (inst_in),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    assign inst_ready = !full;
    assign head_valid = !empty;
    assign head_class = decode_class(head[WORD_SIZE-1 -: OPCODE_WIDTH]);
    assign legal      = (head_class != FU_CLASS_NONE);

    genvar gi;
    generate
        for (gi = 0; gi < FU_NUM; gi++) begin : g_station
            assign alu_range[gi]  = (gi >= ALU_FU_BASE) && (gi < ALU_FU_BASE + ALU_FU_CNT);
            assign mem_range[gi]  = (gi >= MEM_FU_BASE) && (gi < MEM_FU_BASE + MEM_FU_CNT);
            // A station just broadcast to is not busy yet, so it is masked for one decision.
            assign claim_next[gi] = issue && (cand == FU_INDEX'(gi));
        end
    endgenerate

    assign class_range = (head_class == FU_CLASS_ALU) ? alu_range :
                         (head_class == FU_CLASS_MEM) ? mem_range : '0;
    assign free_mask   = ~busy_in & ~claim_reg & class_range;

    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        for (int i = FU_NUM - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                cand       = FU_INDEX'(i);
                cand_found = 1'b1;
            end
        end
    end

    assign issue = head_valid && legal && cand_found && !rb_full && !flush;
    assign drop  = head_valid && !legal && !flush;
    assign pop   = issue || drop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fu_reg       <= FU_NONE;
            rb_index_reg <= '0;
            inst_reg     <= '0;
            rb_alloc_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            claim_reg    <= '0;
        end else begin
            fu_reg       <= issue ? cand : FU_NONE;
            rb_alloc_reg <= issue;
            illegal_reg  <= drop;
            claim_reg    <= claim_next;
            if (issue) begin
                rb_index_reg <= rb_tail;
                inst_reg     <= head;
            end
        end
    end

    assign fu       = fu_reg;
    assign RB_index = rb_index_reg;
    assign inst     = inst_reg;
    assign rb_alloc = rb_alloc_reg;
    assign illegal  = illegal_reg;

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_issued_reg;
    logic [31:0] stat_stall_reg;
    logic        stall;

    assign stall = head_valid && legal && !issue;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_issued_reg <= '0;
            stat_stall_reg  <= '0;
        end else begin
            if (issue && (stat_issued_reg != '1)) stat_issued_reg <= stat_issued_reg + 32'd1;
            if (stall && (stat_stall_reg != '1))  stat_stall_reg  <= stat_stall_reg + 32'd1;
        end
    end

    assign stat_issued = stat_issued_reg;
    assign stat_stall  = stat_stall_reg;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: issue, claim masking, stalls, rb_full, illegal drop and flush.
module tb_issue_unit;
    import issue_unit_pkg::*;

    logic                 clk;
    logic                 reset_n;
    logic [WORD_SIZE-1:0] inst_in;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [FU_NUM-1:0]    busy_in;
    logic                 rb_full;
    logic [RB_INDEX-1:0]  rb_tail;
    logic                 rb_alloc;
    logic                 flush;
    logic [FU_INDEX-1:0]  fu;
    logic [RB_INDEX-1:0]  RB_index;
    logic [WORD_SIZE-1:0] inst;
    logic                 illegal;
`ifdef ISSUE_STATS_EN
    logic [31:0]          stat_issued;
    logic [31:0]          stat_stall;
`endif

    int checks_total;
    int checks_passed;

    issue_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .busy_in    (busy_in),
        .rb_full    (rb_full),
        .rb_tail    (rb_tail),
        .rb_alloc   (rb_alloc),
        .flush      (flush),
        .fu         (fu),
        .RB_index   (RB_index),
        .inst       (inst),
        .illegal    (illegal)
`ifdef ISSUE_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-16s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_SIZE-1:0] mk(input logic [OPCODE_WIDTH-1:0] op,
                                                input logic [25:0] low);
        mk = {op, low};
    endfunction

    localparam logic [31:0] NONE = 32'(FU_NONE);

    logic [WORD_SIZE-1:0] w_addi, w_add1, w_add2, w_add3, w_sub, w_mul, w_load, w_ill, w_mul2;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        w_addi = mk(INST_ADDI,  26'h0000A1);
        w_add1 = mk(INST_ADD,   26'h0000B1);
        w_add2 = mk(INST_ADD,   26'h0000B2);
        w_add3 = mk(INST_ADD,   26'h0000B3);
        w_sub  = mk(INST_SUB,   26'h0000C1);
        w_mul  = mk(INST_MUL,   26'h0000C2);
        w_load = mk(INST_LOAD,  26'h0000D1);
        w_ill  = mk(6'h3F,      26'h0000E1);
        w_mul2 = mk(INST_MUL,   26'h0000F1);

        reset_n = 1'b0; inst_in = '0; inst_valid = 1'b0; busy_in = '0;
        rb_full = 1'b0; rb_tail = '0; flush = 1'b0;
        step(); step();
        check("rst_fu",       32'(fu), NONE);
        check("rst_rbidx",    32'(RB_index), 32'd0);
        check("rst_inst",     inst, 32'd0);
        check("rst_alloc",    32'(rb_alloc), 32'd0);
        check("rst_illegal",  32'(illegal), 32'd0);
        check("rst_ready",    32'(inst_ready), 32'd1);
        reset_n = 1'b1;

        // Single ADDI: one-cycle latency, one-cycle broadcast
        inst_in = w_addi; inst_valid = 1'b1; rb_tail = 3'd5;
        step();
        check("addi_push_fu", 32'(fu), NONE);
        inst_valid = 1'b0;
        step();
        check("addi_fu",      32'(fu), 32'd0);
        check("addi_rbidx",   32'(RB_index), 32'd5);
        check("addi_alloc",   32'(rb_alloc), 32'd1);
        check("addi_inst",    inst, w_addi);
        step();
        check("addi_end_fu",  32'(fu), NONE);
        check("addi_end_al",  32'(rb_alloc), 32'd0);
        check("addi_hold",    inst, w_addi);

        // Back-to-back ADDs: claim steers second to station 1, third stalls
        inst_in = w_add1; inst_valid = 1'b1;
        step();
        inst_in = w_add2; rb_tail = 3'd1;
        step();
        check("b2b_fu0",      32'(fu), 32'd0);
        check("b2b_rb0",      32'(RB_index), 32'd1);
        inst_in = w_add3; busy_in = 4'b0001; rb_tail = 3'd2;
        step();
        check("b2b_fu1",      32'(fu), 32'd1);
        check("b2b_rb1",      32'(RB_index), 32'd2);
        inst_valid = 1'b0; busy_in = 4'b0011; rb_tail = 3'd3;
        step();
        check("b2b_stall_fu", 32'(fu), NONE);
        check("b2b_stall_al", 32'(rb_alloc), 32'd0);
        check("b2b_inst_hold", inst, w_add2);
        step();
        check("b2b_stall2",   32'(fu), NONE);
        busy_in = 4'b0010;
        step();
        check("b2b_fu_rel",   32'(fu), 32'd0);
        check("b2b_rb_rel",   32'(RB_index), 32'd3);
        check("b2b_inst3",    inst, w_add3);
        busy_in = 4'b0000;
        step();
        check("b2b_idle",     32'(fu), NONE);

        // ALU stations busy while MEM free: stall and fill FIFO
        inst_in = w_sub; inst_valid = 1'b1; busy_in = 4'b0011;
        step();
        check("busy_fu",      32'(fu), NONE);
        check("busy_ready1",  32'(inst_ready), 32'd1);
        inst_in = w_mul;
        step();
        check("busy_fu2",     32'(fu), NONE);
        check("busy_full",    32'(inst_ready), 32'd0);
        inst_valid = 1'b0; busy_in = 4'b0001; rb_tail = 3'd4;
        step();
        check("busy_rel_fu",  32'(fu), 32'd1);
        check("busy_rel_rb",  32'(RB_index), 32'd4);
        check("busy_rel_rdy", 32'(inst_ready), 32'd1);
        busy_in = 4'b0000;
        step();
        check("busy_mul_fu",  32'(fu), 32'd0);
        check("busy_mul_inst", inst, w_mul);
        step();
        check("busy_idle",    32'(fu), NONE);

        // rb_full blocks a LOAD
        inst_in = w_load; inst_valid = 1'b1; rb_full = 1'b1;
        step();
        inst_valid = 1'b0;
        step();
        check("rbf_fu",       32'(fu), NONE);
        check("rbf_alloc",    32'(rb_alloc), 32'd0);
        rb_full = 1'b0; rb_tail = 3'd2;
        step();
        check("rbf_rel_fu",   32'(fu), 32'd2);
        check("rbf_rel_rb",   32'(RB_index), 32'd2);
        check("rbf_rel_al",   32'(rb_alloc), 32'd1);
        step();
        check("rbf_idle",     32'(fu), NONE);

        // Illegal opcode dropped, following MUL issues
        inst_in = w_ill; inst_valid = 1'b1;
        step();
        inst_in = w_mul2;
        step();
        check("ill_pulse",    32'(illegal), 32'd1);
        check("ill_fu",       32'(fu), NONE);
        check("ill_alloc",    32'(rb_alloc), 32'd0);
        inst_valid = 1'b0; rb_tail = 3'd6;
        step();
        check("ill_end",      32'(illegal), 32'd0);
        check("ill_mul_fu",   32'(fu), 32'd0);
        check("ill_mul_rb",   32'(RB_index), 32'd6);
        check("ill_mul_inst", inst, w_mul2);
        step();

        // Flush with two entries queued and a concurrent push
        inst_in = w_add1; inst_valid = 1'b1; busy_in = 4'b1111;
        step();
        inst_in = w_add2;
        step();
        check("fl_full",      32'(inst_ready), 32'd0);
        inst_in = w_add3; flush = 1'b1; busy_in = 4'b0000;
        step();
        check("fl_ready",     32'(inst_ready), 32'd1);
        check("fl_fu",        32'(fu), NONE);
        check("fl_alloc",     32'(rb_alloc), 32'd0);
        flush = 1'b0; inst_valid = 1'b0;
        step();
        check("fl_empty_fu",  32'(fu), NONE);
        check("fl_empty_al",  32'(rb_alloc), 32'd0);

        // Flush discards a push accepted-able on the same edge
        inst_in = w_sub; inst_valid = 1'b1; busy_in = 4'b1111;
        step();
        inst_in = w_mul; flush = 1'b1;
        step();
        flush = 1'b0; inst_valid = 1'b0; busy_in = 4'b0000;
        step();
        check("fl2_fu",       32'(fu), NONE);
        check("fl2_alloc",    32'(rb_alloc), 32'd0);
        check("fl2_inst",     inst, w_mul2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
